mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequencing controller that shares the single-ported memory_block between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Arbitrates between the two ports and holds memory address, data, read, write and byte controls stable for a fixed access window.
- Registers read data and returns it with a one-cycle ready pulse.
- Rejects misaligned word accesses without touching memory.

Parameters:
- ACCESS_CYCLES, 1: cycles the memory controls are held per access (1..15).
- ROUND_ROBIN, 1: 1 = alternate on conflict; 0 = D always wins.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  IF read request, held until if_ready
- if_addr  in  18  IF byte address
- if_ready  out  1  one-cycle completion pulse to IF
- if_rdata  out  32  IF read data, valid while if_ready
- if_err  out  1  misaligned IF access, valid while if_ready
- d_req  in  1  D request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_byte  in  1  byte operation
- d_addr  in  18  D byte address
- d_wdata  in  32  D store data
- d_ready  out  1  one-cycle completion pulse to D
- d_rdata  out  32  D load data, valid while d_ready
- d_err  out  1  misaligned D word access, valid while d_ready
- mem_address  out  18  to memory_block address
- mem_read  out  1  to memory_block memRead
- mem_write  out  1  to memory_block memWrite
- mem_write_data  out  32  to memory_block write_data
- mem_byte  out  1  to memory_block byteOperations
- mem_read_data  in  32  from memory_block read_data
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (asynchronous, immediate):
  - state=IDLE, cycle counter=0, last_grant=IF.
  - All outputs 0; in-flight access is abandoned and no ready is issued.
- IDLE:
  - On a rising edge with any req high, grant one port.
  - Only one port requesting: that port wins.
  - Both requesting, ROUND_ROBIN=1: the port not in last_grant wins. After reset, D wins the first tie.
  - Both requesting, ROUND_ROBIN=0: D wins.
  - On grant, latch granted port, address, we, byte, wdata; update last_grant.
- Alignment check at grant:
  - Misaligned means a word access (IF always, D with d_byte=0) with addr[1:0] != 0.
  - Misaligned: go straight to RESP with err=1 and rdata=0; memory controls stay 0.
  - Aligned: go to ACCESS with counter=0.
- ACCESS:
  - Drive mem_address, mem_write_data and mem_byte from the latched values.
  - Load: mem_read=1, mem_write=0. Store: mem_write=1, mem_read=0.
  - Counter increments each cycle.
  - When counter = ACCESS_CYCLES-1: capture mem_read_data into the granted port's rdata register (loads only; stores return rdata=0) and go to RESP.
- RESP:
  - Exactly one cycle; granted port's ready=1, its err as latched.
  - All mem_* outputs 0.
  - Next state is IDLE unconditionally. Requests are not sampled in RESP: the requester drops req on the ready edge.
- Outside ACCESS, mem_read, mem_write, mem_address, mem_write_data and mem_byte are 0.
- Latency and throughput:
  - Aligned access: req sampled at edge N; mem controls active for cycles N+1..N+ACCESS_CYCLES; ready high in cycle N+ACCESS_CYCLES+1.
  - Throughput is one access per ACCESS_CYCLES+2 cycles.
- Edge cases:
  - req dropped mid-ACCESS: the access still completes and ready still pulses. A store is never aborted once in ACCESS.
  - Address or data changing mid-access: no effect (latched values are used).
  - if_ready and d_ready are never high together.
  - Non-granted port's rdata and err outputs are 0.

Test Plan:
- Reset, then IF only, if_addr=18'd4, memory word 1 = 32'h0000_07B8, ACCESS_CYCLES=1 -> mem_read=1 and mem_address=4 for one cycle; if_ready one cycle later with if_rdata=32'h0000_07B8.
- D store, d_addr=18'd16, d_wdata=32'h0000_00B8, d_byte=0, then D load from 16 -> mem_write=1 exactly one cycle; load returns d_rdata=32'h0000_00B8, d_err=0.
- if_req and d_req both held high across 4 accesses, ROUND_ROBIN=1 -> grant order D, IF, D, IF; the two ready signals never overlap.
- Same stimulus with ROUND_ROBIN=0 -> D granted all 4 times while d_req stays high.
- D word load at d_addr=18'd1 -> d_ready and d_err high in the cycle after grant, d_rdata=0, mem_read never asserted. D byte load at 18'd1 -> normal access with mem_byte=1, d_err=0.
- ACCESS_CYCLES=3, assert reset in the 2nd ACCESS cycle of a store -> all outputs 0 immediately, no ready pulse, next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port (IF, read only) and the load/store data port (D).
// Ports:
//   clk, reset                     rising-edge clock, async active-high reset
//   if_req/if_addr                 IF read request and byte address
//   if_ready/if_rdata/if_err       IF completion pulse, data, misalign flag
//   d_req/d_we/d_byte/d_addr/d_wdata  D request, store flag, byte op, addr, data
//   d_ready/d_rdata/d_err          D completion pulse, data, misalign flag
//   mem_address/mem_read/mem_write/mem_write_data/mem_byte  memory controls
//   mem_read_data                  memory read data
//   busy                           high whenever the arbiter is not idle
module mem_port_arbiter #(
    parameter int ACCESS_CYCLES = 1,
    parameter bit ROUND_ROBIN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [17:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [17:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [17:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    output logic        mem_byte,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        last_d;
    logic        gnt_d;
    logic [17:0] addr_q;
    logic        we_q;
    logic        byte_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        any_req;
    logic        pick_d;
    logic [17:0] sel_addr;
    logic        misal;
    logic        last_cyc;

    assign any_req  = if_req | d_req;
    assign sel_addr = pick_d ? d_addr : if_addr;
    // IF fetches are always word accesses; D is a word access unless d_byte.
    assign misal    = (!pick_d || !d_byte) && (sel_addr[1:0] != 2'b00);
    assign last_cyc = (cnt == LAST);

    // On a tie, round robin favours the port that did not win last time.
    always_comb begin
        pick_d = d_req;
        if (d_req && if_req) begin
            pick_d = ROUND_ROBIN ? !last_d : 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = misal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (last_cyc) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            last_d  <= 1'b0;
            gnt_d   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        cnt     <= '0;
                        gnt_d   <= pick_d;
                        last_d  <= pick_d;
                        addr_q  <= sel_addr;
                        we_q    <= pick_d & d_we;
                        byte_q  <= pick_d & d_byte;
                        wdata_q <= pick_d ? d_wdata : 32'h0;
                        err_q   <= misal;
                        rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (last_cyc) begin
                        rdata_q <= we_q ? 32'h0 : mem_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if_ready       = 1'b0;
        if_rdata       = '0;
        if_err         = 1'b0;
        d_ready        = 1'b0;
        d_rdata        = '0;
        d_err          = 1'b0;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;
        mem_byte       = 1'b0;
        busy           = (state != IDLE);
        unique case (state)
            ACCESS: begin
                mem_address    = addr_q;
                mem_read       = !we_q;
                mem_write      = we_q;
                mem_write_data = wdata_q;
                mem_byte       = byte_q;
            end
            RESP: begin
                if (gnt_d) begin
                    d_ready = 1'b1;
                    d_rdata = rdata_q;
                    d_err   = err_q;
                end else begin
                    if_ready = 1'b1;
                    if_rdata = rdata_q;
                    if_err   = err_q;
                end
            end
            default: ;
        endcase
    end

endmodule
